// File: rtl/clb_cfg_pkg.sv
// Shared types and helpers for the CLB tile configuration loader.
// The signature function is also used by the tile-level readback checker.
package clb_cfg_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SET  = 2'd2,
        DONE = 2'd3
    } cfg_state_e;

    // Widest signature the shared helper supports
    localparam int SIG_MAX_W = 64;

    // Shift steps needed to empty one config word into the chains
    function automatic int calc_spw(input int word_w, input int num_chains);
        return word_w / num_chains;
    endfunction

    // Config words needed to fill every chain of the tile once
    function automatic int calc_wpf(input int num_chains, input int chain_len, input int word_w);
        return (num_chains * chain_len) / word_w;
    endfunction

    // Rotate-left-by-one within sig_w bits, then fold in the chain tails.
    // Callers zero-extend both operands to SIG_MAX_W and truncate the result.
    function automatic logic [SIG_MAX_W-1:0] sig_update(
        input logic [SIG_MAX_W-1:0] sig,
        input logic [SIG_MAX_W-1:0] tails,
        input int                   sig_w
    );
        logic [SIG_MAX_W-1:0] rot;
        rot    = '0;
        rot[0] = sig[sig_w-1];
        for (int i = 1; i < SIG_MAX_W; i++) begin
            if (i < sig_w) begin
                rot[i] = sig[i-1];
            end
        end
        return rot ^ tails;
    endfunction

endpackage

// File: rtl/clb_cfg_loader_serializer.sv
// Word-to-chain serializer: holds the current config word, emits
// NUM_CHAINS bits per shift step and requests the next word early enough
// that back-to-back words shift with no bubble.
//
// Handshake: a word transfers on any rising edge where i_cfg_valid and
// o_cfg_ready are both high and i_abort is low; o_cfg_ready never depends
// on i_cfg_valid, and a word offered during abort is dropped.
module clb_cfg_serializer
    import clb_cfg_pkg::*;
#(
    parameter int NUM_CHAINS = 4,
    parameter int WORD_W     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_in_load,
    input  logic                  i_abort,
    input  logic                  i_word_room,
    input  logic [WORD_W-1:0]     i_cfg_data,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    output logic                  o_accept,
    output logic                  o_last_step,
    output logic [NUM_CHAINS-1:0] o_cfg_shift,
    output logic                  o_cfg_cen
);

    localparam int SPW = calc_spw(WORD_W, NUM_CHAINS);
    localparam int SLW = $clog2(SPW + 1);

    logic [WORD_W-1:0] r_shreg;
    logic [SLW-1:0]    r_steps_left;
    logic              w_active;

    // Ready/shift decode from the remaining step count
    always_comb begin
        w_active    = i_in_load && (r_steps_left != '0);
        o_last_step = (r_steps_left <= SLW'(1));
        o_cfg_ready = i_in_load && i_word_room && o_last_step;
        o_accept    = i_cfg_valid && o_cfg_ready && !i_abort;
        o_cfg_cen   = w_active;
        o_cfg_shift = w_active ? r_shreg[NUM_CHAINS-1:0] : '0;
    end

    // Shift register and step counter; a new word overrides the last shift
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_shreg      <= '0;
            r_steps_left <= '0;
        end else if (i_clear) begin
            r_shreg      <= '0;
            r_steps_left <= '0;
        end else if (o_accept) begin
            r_shreg      <= i_cfg_data;
            r_steps_left <= SLW'(SPW);
        end else if (w_active) begin
            r_shreg      <= r_shreg >> NUM_CHAINS;
            r_steps_left <= r_steps_left - SLW'(1);
        end
    end

endmodule

// File: rtl/clb_tile_cfg_loader.sv
// Per-tile configuration loader: streams config words into NUM_CHAINS
// parallel shift chains, commits them with a cfg_set strobe and builds a
// readback signature of the old chain contents. i_rst is active-low.
module clb_tile_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int NUM_CHAINS = 4,
    parameter int CHAIN_LEN  = 320,
    parameter int WORD_W     = 32,
    parameter int SET_CYCLES = 2,
    parameter int SIG_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [WORD_W-1:0]     i_cfg_data,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    output logic [NUM_CHAINS-1:0] o_cfg_shift,
    output logic                  o_cfg_cen,
    output logic                  o_cfg_set,
    input  logic [NUM_CHAINS-1:0] i_cfg_shift_ret,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_aborted,
    output logic [SIG_W-1:0]      o_rb_sig,
    output cfg_state_e            o_dbg_state
);

    localparam int WPF = calc_wpf(NUM_CHAINS, CHAIN_LEN, WORD_W);
    localparam int WCW = $clog2(WPF + 1);
    localparam int SCW = $clog2(SET_CYCLES + 1);

    cfg_state_e       r_state;
    cfg_state_e       w_next_state;
    logic [WCW-1:0]   r_word_cnt;
    logic [SCW-1:0]   r_set_cnt;
    logic [SIG_W-1:0] r_rb_sig;
    logic             r_aborted;

    logic             w_start_ok;
    logic             w_abort_act;
    logic             w_word_room;
    logic             w_in_load;
    logic             w_accept;
    logic             w_last_step;
    logic [SIG_W-1:0] w_rb_next;

    // Qualified control events; abort beats start in IDLE
    always_comb begin
        w_start_ok  = (r_state == IDLE) && i_start && !i_abort;
        w_abort_act = i_abort && (r_state != IDLE);
        w_word_room = (r_word_cnt < WCW'(WPF));
        w_in_load   = (r_state == LOAD);
    end

    clb_cfg_serializer #(
        .NUM_CHAINS (NUM_CHAINS),
        .WORD_W     (WORD_W)
    ) u_serializer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_start_ok || w_abort_act),
        .i_in_load   (w_in_load),
        .i_abort     (i_abort),
        .i_word_room (w_word_room),
        .i_cfg_data  (i_cfg_data),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .o_accept    (w_accept),
        .o_last_step (w_last_step),
        .o_cfg_shift (o_cfg_shift),
        .o_cfg_cen   (o_cfg_cen)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: LOAD ends on the last shift of the last word
    always_comb begin
        w_next_state = r_state;
        if (w_abort_act) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start_ok) w_next_state = LOAD;
                LOAD:    if (!w_word_room && w_last_step) w_next_state = SET;
                SET:     if (r_set_cnt == SCW'(SET_CYCLES - 1)) w_next_state = DONE;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the current state
    always_comb begin
        o_busy      = (r_state != IDLE);
        o_cfg_set   = (r_state == SET);
        o_done      = (r_state == DONE);
        o_dbg_state = r_state;
    end

    // Commit-strobe length counter, running only while in SET
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_set_cnt <= '0;
        end else if (r_state == SET) begin
            r_set_cnt <= r_set_cnt + SCW'(1);
        end else begin
            r_set_cnt <= '0;
        end
    end

    // Accepted-word counter for the current frame
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_word_cnt <= '0;
        end else if (w_start_ok) begin
            r_word_cnt <= '0;
        end else if (w_accept) begin
            r_word_cnt <= r_word_cnt + WCW'(1);
        end
    end

    // Signature next value from the tails leaving the chains this cycle
    always_comb begin
        w_rb_next = SIG_W'(sig_update(SIG_MAX_W'(r_rb_sig), SIG_MAX_W'(i_cfg_shift_ret), SIG_W));
    end

    // Readback signature: cleared on start, folded on every chain shift
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rb_sig <= '0;
        end else if (w_start_ok) begin
            r_rb_sig <= '0;
        end else if (o_cfg_cen) begin
            r_rb_sig <= w_rb_next;
        end
    end

    // Sticky abort flag, cleared by the next accepted start
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_aborted <= 1'b0;
        end else if (w_abort_act) begin
            r_aborted <= 1'b1;
        end else if (w_start_ok) begin
            r_aborted <= 1'b0;
        end
    end

    assign o_aborted = r_aborted;
    assign o_rb_sig  = r_rb_sig;

endmodule

// File: tb/tb_clb_tile_cfg_loader.sv
// Directed bench for clb_tile_cfg_loader with a 4x8 chain model.
module tb_clb_tile_cfg_loader;

  localparam int NC = 4;
  localparam int CL = 8;
  localparam int WW = 8;
  localparam int SC = 2;
  localparam int SW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [NC-1:0] cfg_shift;
  logic          cfg_cen;
  logic          cfg_set;
  logic [NC-1:0] cfg_shift_ret;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [SW-1:0] rb_sig;
  clb_cfg_pkg::cfg_state_e dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // chain model and scoreboard state
  logic [CL-1:0] chain [NC];
  logic          preload_req = 1'b0;
  logic [CL-1:0] preload_val = '0;
  logic [NC-1:0] exp_q[$];
  int            cen_cnt = 0;
  int            run_cnt = 0;
  int            set_cnt = 0;
  int            done_cnt = 0;
  logic          prev_cen = 1'b0;
  int            b_cen, b_run, b_set, b_done;

  logic [WW-1:0] words [4];

  clb_tile_cfg_loader #(
    .NUM_CHAINS (NC),
    .CHAIN_LEN  (CL),
    .WORD_W     (WW),
    .SET_CYCLES (SC),
    .SIG_W      (SW)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_abort         (abort),
    .i_cfg_data      (cfg_data),
    .i_cfg_valid     (cfg_valid),
    .o_cfg_ready     (cfg_ready),
    .o_cfg_shift     (cfg_shift),
    .o_cfg_cen       (cfg_cen),
    .o_cfg_set       (cfg_set),
    .i_cfg_shift_ret (cfg_shift_ret),
    .o_busy          (busy),
    .o_done          (done),
    .o_aborted       (aborted),
    .o_rb_sig        (rb_sig),
    .o_dbg_state     (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // chain model: head at bit 0, tail at bit CL-1
  always @(posedge clk) begin
    if (preload_req) begin
      for (int c = 0; c < NC; c++) chain[c] <= preload_val;
    end else if (cfg_cen) begin
      for (int c = 0; c < NC; c++) chain[c] <= {chain[c][CL-2:0], cfg_shift[c]};
    end
  end

  always_comb begin
    cfg_shift_ret = '0;
    for (int c = 0; c < NC; c++) cfg_shift_ret[c] = chain[c][CL-1];
  end

  // monitor / scoreboard on the falling edge
  always @(negedge clk) begin
    prev_cen <= cfg_cen;
    if (cfg_cen) begin
      cen_cnt <= cen_cnt + 1;
      if (!prev_cen) run_cnt <= run_cnt + 1;
      if (exp_q.size() == 0) check("shift_extra", 32'd1, 32'd0);
      else check("shift_seq", {28'd0, cfg_shift}, {28'd0, exp_q.pop_front()});
    end
    if (cfg_set) set_cnt <= set_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // driver tasks (all called at a falling edge)
  task automatic snap();
    b_cen = cen_cnt; b_run = run_cnt; b_set = set_cnt; b_done = done_cnt;
  endtask

  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_frame_exp();
    for (int k = 1; k <= 8; k++) exp_q.push_back(NC'(k));
  endtask

  task automatic send_word(input logic [WW-1:0] d);
    bit ok = 0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (cfg_ready) begin
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_range(input int first, input int last, input bit gap);
    for (int w = first; w <= last; w++) begin
      send_word(words[w]);
      if (gap) begin
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run_frame(input bit gap);
    push_frame_exp();
    pulse_start();
    send_range(0, 3, gap);
    wait_done();
  endtask

  initial begin
    words[0] = 8'h21; words[1] = 8'h43; words[2] = 8'h65; words[3] = 8'h87;
    rst = 1'b0; start = 1'b0; abort = 1'b0; cfg_data = '0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_ctrl",  {28'd0, cfg_ready, cfg_cen, cfg_set, done}, 32'd0);
    check("rst_flags", {31'd0, aborted}, 32'd0);
    check("rst_sig",   {16'd0, rb_sig}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: back-to-back frame into zeroed chains
    preload(8'h00);
    snap();
    run_frame(0);
    check("s1_cen_cnt",  cen_cnt - b_cen, 8);
    check("s1_cen_runs", run_cnt - b_run, 1);
    check("s1_set_cyc",  set_cnt - b_set, 2);
    check("s1_done_cnt", done_cnt - b_done, 1);
    check("s1_exp_left", exp_q.size(), 0);
    check("s1_chain0",   {24'd0, chain[0]}, 32'hAA);
    check("s1_chain1",   {24'd0, chain[1]}, 32'h66);
    check("s1_chain2",   {24'd0, chain[2]}, 32'h1E);
    check("s1_chain3",   {24'd0, chain[3]}, 32'h01);
    check("s1_sig",      {16'd0, rb_sig}, 32'h0);
    check("s1_idle",     {31'd0, busy}, 32'd0);

    // 2: gapped stream
    snap();
    run_frame(1);
    check("s2_cen_cnt",  cen_cnt - b_cen, 8);
    check("s2_cen_runs", run_cnt - b_run, 4);
    check("s2_done_cnt", done_cnt - b_done, 1);
    check("s2_exp_left", exp_q.size(), 0);

    // 3: readback of all-ones chains
    preload(8'hFF);
    run_frame(0);
    check("s3_sig", {16'd0, rb_sig}, 32'h0505);
    repeat (3) @(negedge clk);
    check("s3_sig_hold", {16'd0, rb_sig}, 32'h0505);

    // 4: abort after two words
    snap();
    exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
    pulse_start();
    send_word(words[0]);
    send_word(words[1]);
    cfg_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("s4_busy",    {31'd0, busy}, 32'd0);
    check("s4_outs",    {29'd0, cfg_cen, cfg_set, cfg_ready}, 32'd0);
    check("s4_aborted", {31'd0, aborted}, 32'd1);
    @(negedge clk);
    check("s4_no_set",  set_cnt - b_set, 0);
    check("s4_no_done", done_cnt - b_done, 0);
    check("s4_exp_left", exp_q.size(), 0);
    snap();
    push_frame_exp();
    pulse_start();
    check("s4_abort_clr", {30'd0, aborted, busy}, 32'd1);
    send_range(0, 3, 0);
    wait_done();
    check("s4_done_cnt", done_cnt - b_done, 1);

    // 5: async reset during SET
    push_frame_exp();
    pulse_start();
    send_range(0, 3, 0);
    begin
      bit seen = 0;
      for (int n = 0; n < 40; n++) begin
        if (cfg_set) begin
          seen = 1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) check("s5_set_timeout", 32'd0, 32'd1);
    end
    rst = 1'b0;
    #1;
    check("s5_set_drop", {31'd0, cfg_set}, 32'd0);
    check("s5_outs",     {24'd0, busy, done, aborted, cfg_ready, cfg_cen, 3'd0}, 32'd0);
    check("s5_shift",    {28'd0, cfg_shift}, 32'd0);
    check("s5_sig",      {16'd0, rb_sig}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    snap();
    run_frame(0);
    check("s5_cen_cnt",  cen_cnt - b_cen, 8);
    check("s5_done_cnt", done_cnt - b_done, 1);
    check("s5_exp_left", exp_q.size(), 0);

    // 6: cfg_valid in IDLE and start during LOAD are ignored
    cfg_data  = 8'hFF;
    cfg_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("s6_idle_ready", {31'd0, cfg_ready}, 32'd0);
    end
    cfg_valid = 1'b0;
    check("s6_idle_busy", {31'd0, busy}, 32'd0);
    snap();
    push_frame_exp();
    pulse_start();
    send_word(words[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_range(1, 3, 0);
    wait_done();
    check("s6_done_cnt", done_cnt - b_done, 1);
    check("s6_cen_cnt",  cen_cnt - b_cen, 8);
    check("s6_exp_left", exp_q.size(), 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clb_tile_cfg_loader.md
Name: clb_tile_cfg_loader

Overview:
- Per-tile configuration loader for the next-generation CLB tile. It drives NUM_CHAINS parallel config shift chains in place of the single serial shift/set chain.
- Accepts config words over a valid/ready stream and serialises them into the chains, NUM_CHAINS bits per cycle, gated by cfg_cen.
- When the frame is complete it pulses cfg_set to commit the configuration.
- Captures a readback signature of the old chain contents as they shift out of the chain tails.

Parameters:
- NUM_CHAINS, 4, number of parallel config shift chains in the tile.
- CHAIN_LEN, 320, bits per chain. CHAIN_LEN % (WORD_W/NUM_CHAINS) must be 0.
- WORD_W, 32, config word width. WORD_W % NUM_CHAINS must be 0.
- SET_CYCLES, 2, number of cycles cfg_set is held high on commit (>=1).
- SIG_W, 16, readback signature width (>= NUM_CHAINS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame load. Ignored unless the block is in IDLE.
- abort  in  1  abandons the load and returns to IDLE. Takes priority over all other inputs.
- cfg_data  in  WORD_W  config word. Bit [k*NUM_CHAINS+c] goes to chain c on shift step k (LSB first).
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  loader accepts cfg_data this cycle.
- cfg_shift  out  NUM_CHAINS  serial data, one bit per chain head.
- cfg_cen  out  1  chain shift enable; the chains advance only when this is high.
- cfg_set  out  1  commit strobe to all tile config cells.
- cfg_shift_ret  in  NUM_CHAINS  chain tail outputs (returning old contents).
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse when a frame has been committed.
- aborted  out  1  sticky flag: last load was aborted. Cleared by start.
- rb_sig  out  SIG_W  readback signature. Stable from done until the next start.

Behaviour:
- Derived constants:
  - SPW = WORD_W/NUM_CHAINS (shift steps per word).
  - WPF = NUM_CHAINS*CHAIN_LEN/WORD_W (words per frame).
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, including rb_sig, aborted and the counters.
- Reset mid-load leaves the chains partially written. A new full frame is required; no recovery is attempted.
- State machine: IDLE -> LOAD -> SET -> DONE -> IDLE.
- IDLE:
  - start=1 -> LOAD on the next cycle.
  - word_cnt, steps_left and rb_sig are cleared, and aborted is cleared, on the same edge.
- LOAD, handshake:
  - cfg_ready = (word_cnt<WPF) && (steps_left<=1).
  - steps_left<=1 means the previous word is either empty or on its last step, so back-to-back words shift with no bubble.
  - On cfg_valid&&cfg_ready: shreg<=cfg_data, steps_left<=SPW, word_cnt++.
- LOAD, shifting:
  - In any cycle with steps_left>0: cfg_cen=1, cfg_shift=shreg[NUM_CHAINS-1:0].
  - On that edge shreg>>=NUM_CHAINS and steps_left-- (unless a new word loads on the same edge).
  - steps_left==0 -> cfg_cen=0 and cfg_shift=0. The chains hold, so a valid gap is harmless.
- LOAD exit: when word_cnt==WPF and steps_left reaches 0 -> SET.
- Frame size: exactly WPF*SPW cycles with cfg_cen=1 per frame, i.e. CHAIN_LEN shifts per chain.
- SET: cfg_set=1 for exactly SET_CYCLES cycles, with cfg_cen=0 and cfg_ready=0. Then -> DONE.
- DONE: done=1 for one cycle, then -> IDLE. cfg_set is never asserted outside SET.
- Signature:
  - On every cfg_cen=1 cycle: rb_sig <= {rb_sig[SIG_W-2:0], rb_sig[SIG_W-1]} ^ zero_ext(cfg_shift_ret).
  - cfg_shift_ret is sampled in the same cycle as the shift.
- Abort (any state other than IDLE):
  - Next state is IDLE.
  - cfg_cen, cfg_set and cfg_ready go 0 from the next cycle.
  - aborted<=1; done is not pulsed.
  - Abort arriving in the same cycle as a handshake: the word is dropped.
- Simultaneous start and abort in IDLE: abort wins, start is ignored.
- start while busy: ignored.
- cfg_valid outside LOAD: ignored (cfg_ready=0).
- Counter widths: word_cnt is clog2(WPF+1) bits; steps_left is clog2(SPW+1) bits. No wrap-around is possible.

Decomposition:
- Shared package clb_cfg_pkg holds:
  - state enum {IDLE, LOAD, SET, DONE};
  - SPW/WPF derivation functions;
  - the signature-update function, reused by the tile-level readback checker.
- One sub-module: clb_cfg_serializer (shreg, steps_left, cfg_shift/cfg_cen, ready generation).
- The FSM, counters and signature stay in the top module.

Test Plan:
All scenarios use NUM_CHAINS=4, CHAIN_LEN=8, WORD_W=8, SET_CYCLES=2, giving SPW=2 and WPF=4.
1. Back-to-back frame: start, then words 0x21,0x43,0x65,0x87 with valid held high.
   - cfg_cen is high for 8 consecutive cycles.
   - cfg_shift sequence is 1,2,3,4,5,6,7,8.
   - cfg_set is high for 2 cycles, then done pulses once.
2. Gapped stream: valid low for 3 cycles between each word.
   - Same cfg_shift sequence as scenario 1.
   - cfg_cen=0 during the gaps; total cfg_cen cycles = 8.
3. Readback: chain model preloaded so that cfg_shift_ret=4'hF on every shift.
   - After done, rb_sig equals the golden signature computed with the package function (8 updates from 0).
4. Abort after 2 words.
   - busy falls on the next cycle; cfg_set is never asserted; aborted=1; done=0.
   - A following start clears aborted.
5. Async reset asserted during SET.
   - cfg_set drops immediately; all outputs read 0.
   - After release, a new start loads a full frame normally.
6. start pulsed while in LOAD, and cfg_valid driven in IDLE.
   - Both are ignored; word_cnt is unaffected; cfg_ready stays 0 in IDLE.
